operand_skew_feeder: RTL and testbench

- Upstream stage of the systolic array. On a start command it reads T_C consecutive operand rows (ROW_BITS wide) from operand memory, beginning at a base address.
- It splits each row into SYS_ARRAY_SIZE lanes and presents lane j skewed by j cycles. This produces the diagonal wavefront the PE edge expects.
- Each lane element is carried as a matrix_data_t {data, last}. The final row is tagged last.
- The block instantiates twice: one instance fed by a_addr (row edge) and one fed by b_addr (column edge).

---
 rtl/operand_skew_feeder.sv | 176 +++++++++++++++++
 tb/tb_operand_skew_feeder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_skew_feeder.sv
// operand_skew_feeder: reads DEPTH operand rows from memory and presents them
// to the systolic-array edge as a diagonal wavefront (lane j delayed j cycles).
// Each lane element is a {data, last} pair; the final row of a command is tagged last.

// One lane of the skew network: a capture register followed by SKEW delay
// registers. Data is zeroed whenever the element is not valid so idle lanes
// always show data=0, last=0.
module operand_skew_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int SKEW       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_vld,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] out_data
);

  // Stage 0 is the capture register; stages 1..SKEW are the skew delay.
  logic [SKEW:0]                 vld_pipe;
  logic [SKEW:0]                 last_pipe;
  logic [SKEW:0][DATA_WIDTH-1:0] data_pipe;

  // Shift valid/last/data one stage per cycle; reset clears in-flight elements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      data_pipe <= '0;
    end else begin
      for (int s = SKEW; s > 0; s--) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        last_pipe[s] <= last_pipe[s-1];
        data_pipe[s] <= data_pipe[s-1];
      end
      vld_pipe[0]  <= in_vld;
      last_pipe[0] <= in_vld & in_last;
      data_pipe[0] <= in_vld ? in_data : '0;
    end
  end

  assign out_vld  = vld_pipe[SKEW];
  assign out_last = last_pipe[SKEW];
  assign out_data = data_pipe[SKEW];

endmodule

module operand_skew_feeder #(
  parameter int SIZE       = 4,
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic [ADDR_WIDTH-1:0]        base_addr_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0]        mem_addr_o,
  input  logic [SIZE*DATA_WIDTH-1:0]   mem_rdata_i,
  output logic [SIZE*(DATA_WIDTH+1)-1:0] feed_o,
  output logic [SIZE-1:0]              feed_valid_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } matrix_data_t;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // One counter serves both the row count in READ and the drain count in FLUSH.
  localparam int CNT_MAX = (DEPTH > SIZE + 1) ? DEPTH : SIZE + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  rd_vld;
  logic                  rd_last;
  logic                  row_last;

  assign row_last = (cnt == CNT_W'(DEPTH - 1));

  // Command FSM: READ issues DEPTH consecutive addresses (wrapping naturally at
  // 2^ADDR_WIDTH), FLUSH waits SIZE+1 cycles for the deepest lane to drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      addr  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            addr  <= base_addr_i;
            cnt   <= '0;
            state <= S_READ;
          end
        end
        S_READ: begin
          addr <= addr + 1'b1;
          if (row_last) begin
            cnt   <= '0;
            state <= S_FLUSH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FLUSH: begin
          if (cnt == CNT_W'(SIZE)) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // DONE: a start here relaunches immediately with no idle gap.
          if (start_i) begin
            addr  <= base_addr_i;
            cnt   <= '0;
            state <= S_READ;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Track the one-cycle memory latency so the lanes know when mem_rdata_i is a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
    end else begin
      rd_vld  <= (state == S_READ);
      rd_last <= (state == S_READ) && row_last;
    end
  end

  assign mem_rd_en_o = (state == S_READ);
  assign mem_addr_o  = (state == S_READ) ? addr : '0;
  assign busy_o      = (state == S_READ) || (state == S_FLUSH);
  assign done_o      = (state == S_DONE);

  matrix_data_t [SIZE-1:0] lane_out;

  for (genvar j = 0; j < SIZE; j++) begin : g_lane
    operand_skew_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .SKEW       (j)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (rd_vld),
      .in_last  (rd_last),
      .in_data  (mem_rdata_i[j*DATA_WIDTH +: DATA_WIDTH]),
      .out_vld  (feed_valid_o[j]),
      .out_last (lane_out[j].last),
      .out_data (lane_out[j].data)
    );
  end

  assign feed_o = lane_out;

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Directed bench for operand_skew_feeder: single command, address wrap,
// start-while-busy, back-to-back relaunch, mid-operation reset and idle.
module tb_operand_skew_feeder;

  localparam int SIZE = 4;
  localparam int DEPTH = 4;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int EW = DW + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 start_i = 1'b0;
  logic [AW-1:0]        base_addr_i = '0;
  logic                 busy_o, done_o, mem_rd_en_o;
  logic [AW-1:0]        mem_addr_o;
  logic [SIZE*DW-1:0]   mem_rdata_i = '0;
  logic [SIZE*EW-1:0]   feed_o;
  logic [SIZE-1:0]      feed_valid_o;

  logic [SIZE*DW-1:0]   mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  operand_skew_feeder #(.SIZE(SIZE), .DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .mem_rd_en_o  (mem_rd_en_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rdata_i  (mem_rdata_i),
    .feed_o       (feed_o),
    .feed_valid_o (feed_valid_o)
  );

  always #5 clk = ~clk;

  // Synchronous memory with one cycle of latency; junk when not reading.
  always @(posedge clk) begin
    if (mem_rd_en_o) mem_rdata_i <= mem[mem_addr_o];
    else             mem_rdata_i <= {$urandom, $urandom};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row k at base+k holds byte (off + k*4 + j) in lane j.
  task automatic fill(input logic [AW-1:0] base, input logic [7:0] off);
    for (int k = 0; k < DEPTH; k++) begin
      logic [AW-1:0] a;
      a = base + AW'(k);
      for (int j = 0; j < SIZE; j++) mem[a][j*DW +: DW] = off + 8'(k*4 + j);
    end
  endtask

  // Expected {valid, data, last} for lane j, c cycles after the first READ cycle.
  function automatic logic [EW:0] exp_elem(input int c, input int j, input logic [7:0] off);
    int k;
    k = c - 2 - j;
    if (k >= 0 && k < DEPTH) return {1'b1, off + 8'(k*4 + j), (k == DEPTH-1)};
    return '0;
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if ({busy_o, done_o, mem_rd_en_o} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %b want 000", {busy_o, done_o, mem_rd_en_o});
    end
    checks++;
    if (mem_addr_o !== '0 || feed_valid_o !== '0 || feed_o !== '0) begin
      errors++; $display("FAIL reset_data got addr=%h vld=%b feed=%h want 0", mem_addr_o, feed_valid_o, feed_o);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [EW:0] got, exp;
    fill(10'h010, 8'h00);
    base_addr_i = 10'h010; start_i = 1'b1;
    tick();
    start_i = 1'b0; base_addr_i = '0;
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (mem_rd_en_o !== (c < DEPTH)) begin
        errors++; $display("FAIL single_rd_en c%0d got %b want %b", c, mem_rd_en_o, (c < DEPTH));
      end
      checks++;
      if (mem_addr_o !== ((c < DEPTH) ? 10'h010 + AW'(c) : 10'h000)) begin
        errors++; $display("FAIL single_addr c%0d got %h", c, mem_addr_o);
      end
      checks++;
      if (busy_o !== (c <= DEPTH + SIZE)) begin
        errors++; $display("FAIL single_busy c%0d got %b want %b", c, busy_o, (c <= DEPTH + SIZE));
      end
      checks++;
      if (done_o !== (c == DEPTH + SIZE + 1)) begin
        errors++; $display("FAIL single_done c%0d got %b want %b", c, done_o, (c == DEPTH + SIZE + 1));
      end
      for (int j = 0; j < SIZE; j++) begin
        got = {feed_valid_o[j], feed_o[j*EW +: EW]};
        exp = exp_elem(c, j, 8'h00);
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL single_lane%0d c%0d got %h want %h", j, c, got, exp);
        end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [EW:0] got, exp;
    logic [AW-1:0] want_addr;
    fill(10'h3FE, 8'h80);
    base_addr_i = 10'h3FE; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c < DEPTH) begin
        want_addr = 10'h3FE + AW'(c);
        checks++;
        if (mem_rd_en_o !== 1'b1 || mem_addr_o !== want_addr) begin
          errors++; $display("FAIL wrap_addr c%0d got en=%b addr=%h want %h", c, mem_rd_en_o, mem_addr_o, want_addr);
        end
      end
      for (int j = 0; j < SIZE; j++) begin
        got = {feed_valid_o[j], feed_o[j*EW +: EW]};
        exp = exp_elem(c, j, 8'h80);
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL wrap_lane%0d c%0d got %h want %h", j, c, got, exp);
        end
      end
      tick();
    end
  endtask

  task automatic test_start_busy();
    logic [EW:0] got, exp;
    int dones, bad_reads;
    dones = 0; bad_reads = 0;
    fill(10'h010, 8'h10);
    fill(10'h100, 8'hA0);
    base_addr_i = 10'h010; start_i = 1'b1;
    tick();
    for (int c = 0; c < 15; c++) begin
      if (mem_rd_en_o && mem_addr_o == 10'h100) bad_reads++;
      if (done_o) dones++;
      if (c < 10) begin
        for (int j = 0; j < SIZE; j++) begin
          got = {feed_valid_o[j], feed_o[j*EW +: EW]};
          exp = exp_elem(c, j, 8'h10);
          checks++;
          if (got !== exp) begin
            errors++; $display("FAIL busy_lane%0d c%0d got %h want %h", j, c, got, exp);
          end
        end
      end
      // c==5 is a FLUSH cycle: this start must be ignored.
      start_i = (c == 5);
      base_addr_i = (c == 5) ? 10'h100 : 10'h010;
      tick();
    end
    start_i = 1'b0;
    checks++;
    if (bad_reads !== 0) begin
      errors++; $display("FAIL busy_no_read got %0d reads want 0", bad_reads);
    end
    checks++;
    if (dones !== 1) begin
      errors++; $display("FAIL busy_done_count got %0d want 1", dones);
    end
  endtask

  task automatic test_back_to_back();
    logic [EW:0] got, exp;
    logic exp_en, exp_busy, exp_done;
    logic [AW-1:0] exp_addr;
    fill(10'h010, 8'h00);
    fill(10'h020, 8'h40);
    base_addr_i = 10'h010; start_i = 1'b1;
    tick();
    for (int c = 0; c < 22; c++) begin
      exp_en   = (c < 4) || (c >= 10 && c < 14);
      exp_addr = (c < 4) ? 10'h010 + AW'(c) : (c >= 10 && c < 14) ? 10'h020 + AW'(c - 10) : 10'h000;
      exp_busy = (c <= 8) || (c >= 10 && c <= 18);
      exp_done = (c == 9) || (c == 19);
      checks++;
      if ({mem_rd_en_o, mem_addr_o} !== {exp_en, exp_addr}) begin
        errors++; $display("FAIL b2b_read c%0d got en=%b addr=%h want en=%b addr=%h", c, mem_rd_en_o, mem_addr_o, exp_en, exp_addr);
      end
      checks++;
      if ({busy_o, done_o} !== {exp_busy, exp_done}) begin
        errors++; $display("FAIL b2b_ctrl c%0d got busy=%b done=%b want busy=%b done=%b", c, busy_o, done_o, exp_busy, exp_done);
      end
      for (int j = 0; j < SIZE; j++) begin
        got = {feed_valid_o[j], feed_o[j*EW +: EW]};
        exp = exp_elem(c, j, 8'h00) | exp_elem(c - 10, j, 8'h40);
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL b2b_lane%0d c%0d got %h want %h", j, c, got, exp);
        end
      end
      if (c == 9) base_addr_i = 10'h020;
      if (c == 10) start_i = 1'b0;
      tick();
    end
  endtask

  task automatic test_mid_reset();
    logic [EW:0] got, exp;
    int dones;
    dones = 0;
    fill(10'h010, 8'h00);
    fill(10'h030, 8'h50);
    base_addr_i = 10'h010; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({feed_valid_o, busy_o, mem_rd_en_o, done_o} !== '0) begin
      errors++; $display("FAIL midrst_clear got vld=%b busy=%b en=%b done=%b want 0", feed_valid_o, busy_o, mem_rd_en_o, done_o);
    end
    checks++;
    if (feed_o !== '0) begin
      errors++; $display("FAIL midrst_feed got %h want 0", feed_o);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (done_o || busy_o || mem_rd_en_o || feed_valid_o != '0) dones++;
      tick();
    end
    checks++;
    if (dones !== 0) begin
      errors++; $display("FAIL midrst_quiet got %0d active cycles want 0", dones);
    end
    base_addr_i = 10'h030; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 11; c++) begin
      checks++;
      if (done_o !== (c == 9)) begin
        errors++; $display("FAIL midrst_done c%0d got %b want %b", c, done_o, (c == 9));
      end
      for (int j = 0; j < SIZE; j++) begin
        got = {feed_valid_o[j], feed_o[j*EW +: EW]};
        exp = exp_elem(c, j, 8'h50);
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL midrst_lane%0d c%0d got %h want %h", j, c, got, exp);
        end
      end
      tick();
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 20; c++) begin
      checks++;
      if ({mem_rd_en_o, done_o, busy_o, feed_valid_o} !== '0) begin
        errors++; $display("FAIL idle_ctrl c%0d got en=%b done=%b busy=%b vld=%b want 0", c, mem_rd_en_o, done_o, busy_o, feed_valid_o);
      end
      checks++;
      if (feed_o !== '0) begin
        errors++; $display("FAIL idle_feed c%0d got %h want 0", c, feed_o);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_wrap();
    test_start_busy();
    test_back_to_back();
    test_mid_reset();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
